usb_tx_encoder: RTL and testbench
=================================

USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 8, clock cycles per transmitted bit period (legal values 2 to 16).
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: n_rst  input  1  asynchronous active-low reset.
REQ-004 Port: tx_start  input  1  one-cycle request to begin a packet; honoured only in IDLE.
REQ-005 Port: tx_data  input  8  next packet byte, transmitted LSB first.
REQ-006 Port: tx_valid  input  1  tx_data/tx_last hold a valid byte.
REQ-007 Port: tx_last  input  1  the current tx_data byte is the final byte of the packet.
REQ-008 Port: tx_ack  output  1  one-cycle pulse on the cycle a byte is captured into the shift register.
REQ-009 Port: tx_busy  output  1  packet in progress (SYNC through EOP).
REQ-010 Port: tx_done  output  1  one-cycle pulse at the end of EOP.
REQ-011 Port: tx_err  output  1  one-cycle pulse on underrun.
REQ-012 Port: d_plus  output  1  registered USB D+ line.
REQ-013 Port: d_minus  output  1  registered USB D- line.

Function
REQ-014 States SHALL be IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J; one bit timer counts 0..CLKS_PER_BIT-1 and each line value is held for exactly CLKS_PER_BIT cycles.
REQ-015 IDLE SHALL drive J (d_plus=1, d_minus=0); tx_start in IDLE SHALL enter SYNC, and the first SYNC bit SHALL appear on the line in the next cycle; tx_start outside IDLE SHALL be ignored.
REQ-016 SYNC SHALL send bits 0,0,0,0,0,0,0,1 in that order, so the line shows K,J,K,J,K,J,K,K.
REQ-017 NRZI: a 0 bit SHALL toggle J<->K at the start of its bit period; a 1 bit SHALL hold the previous level.
REQ-018 The byte SHALL be captured on the final cycle of the last SYNC bit period, and on the final cycle of bit 8 of each non-last byte; tx_ack SHALL pulse on that same cycle only.
REQ-019 Underrun: if tx_valid=0 on a capture cycle, the block SHALL pulse tx_err, capture nothing, and enter EOP_SE0.
REQ-020 Bit stuffing: a 3-bit ones counter SHALL increment on each transmitted 1 bit, including the SYNC final 1.
REQ-021 The ones counter SHALL clear on any transmitted 0 bit.
REQ-022 When the counter reaches 6, the next bit period SHALL be STUFF, which sends a 0 (toggle) and clears the counter; the data bit order SHALL resume afterwards.
REQ-023 A stuff bit SHALL be inserted even after the last bit of the last byte if the counter reaches 6 there.
REQ-024 Capture timing SHALL shift by one bit period past any STUFF period that occurs after bit 8.
REQ-025 After the last byte (and any trailing stuff bit), EOP_SE0 SHALL drive d_plus=0, d_minus=0 for 2 bit periods.
REQ-026 EOP_J SHALL then drive J for 1 bit period, after which the block returns to IDLE.
REQ-027 tx_done SHALL pulse on the final cycle of EOP_J, including after an underrun.
REQ-028 tx_busy SHALL be 1 from the first SYNC cycle through the final EOP_J cycle inclusive, and 0 otherwise.
REQ-029 tx_ack, tx_done and tx_err SHALL never be high for more than one consecutive cycle.
REQ-030 tx_ack and tx_err SHALL be mutually exclusive.

Reset
REQ-031 On n_rst=0, regardless of the current cycle, the block SHALL immediately set state IDLE, timer 0, ones counter 0, and shift register 0.
REQ-032 On n_rst=0 the block SHALL immediately set d_plus=1, d_minus=0, tx_busy=0, tx_ack=0, tx_done=0, tx_err=0.
REQ-033 Reset asserted mid-packet SHALL abort the packet with no EOP, and the block SHALL accept tx_start normally after reset releases.

Verification
REQ-034 CLKS_PER_BIT=8; tx_start with tx_data=0x00, tx_valid=1, tx_last=1 -> line K,J,K,J,K,J,K,K, then J,K,J,K,J,K,J,K, then SE0,SE0,J; tx_busy high 152 cycles; one tx_ack; one tx_done.
REQ-035 Single byte 0xFF, tx_last=1 -> stuff 0 after data bit 5; 9 data-phase bit periods; no trailing stuff bit; tx_busy high 160 cycles.
REQ-036 Two bytes 0x3F then 0x00, tx_last on the second -> stuff bit after bit 5 of byte 1; second tx_ack one bit period later than unstuffed timing.
REQ-037 tx_valid=0 at the first capture cycle -> tx_err pulse, no tx_ack, SE0,SE0,J, tx_done; tx_busy high 88 cycles.
REQ-038 tx_start during busy -> ignored, packet unchanged. n_rst pulsed in DATA -> outputs at reset values immediately; a subsequent tx_start sends a complete packet.

Source files
------------

// File: rtl/usb_tx_encoder.sv
// USB-style packet transmitter: SYNC pattern, NRZI-coded data with bit stuffing, then EOP.
// Bytes are pulled over a valid/last interface; a byte missing at capture time ends the packet early.
module usb_tx_encoder #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ack,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic       d_plus,
  output logic       d_minus
);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_e;

  localparam logic [3:0] TIMER_MAX = 4'(CLKS_PER_BIT - 1);

  state_e     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] ones_q, ones_d;
  logic [7:0] shift_q, shift_d;
  logic       last_q, last_d;
  logic       dp_q, dp_d;
  logic       dm_q, dm_d;

  logic bit_end;
  logic send, send_val;
  logic advance, capture, go_eop;

  assign bit_end = (timer_q == TIMER_MAX);
  assign tx_busy = (state_q != IDLE);
  assign d_plus  = dp_q;
  assign d_minus = dm_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch;
    // blocking assignments let the later steps below refine what earlier steps decided.
    state_d   = state_q;
    timer_d   = (state_q == IDLE || bit_end) ? 4'd0 : timer_q + 4'd1;
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;
    shift_d   = shift_q;
    last_d    = last_q;
    dp_d      = dp_q;
    dm_d      = dm_q;
    tx_ack    = 1'b0;
    tx_err    = 1'b0;
    tx_done   = 1'b0;
    send      = 1'b0;
    send_val  = 1'b0;
    advance   = 1'b0;
    capture   = 1'b0;
    go_eop    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d   = SYNC;
          bit_cnt_d = 3'd0;
          send      = 1'b1;
        end
      end
      SYNC: begin
        if (bit_end) begin
          if (bit_cnt_q != 3'd7) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            send      = 1'b1;
            send_val  = (bit_cnt_q == 3'd6);
          end else begin
            capture = 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          if (ones_q == 3'd6) begin
            state_d = STUFF;
            send    = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      STUFF: begin
        if (bit_end) advance = 1'b1;
      end
      EOP_SE0: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd1) begin
            state_d = EOP_J;
            dp_d    = 1'b1;
            dm_d    = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      EOP_J: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // bit_cnt still names the last data bit sent, so a stuff period resumes where it left off
    if (advance) begin
      if (bit_cnt_q != 3'd7) begin
        state_d   = DATA;
        bit_cnt_d = bit_cnt_q + 3'd1;
        shift_d   = shift_q >> 1;
        send      = 1'b1;
        send_val  = shift_q[1];
      end else if (last_q) begin
        go_eop = 1'b1;
      end else begin
        capture = 1'b1;
      end
    end

    if (capture) begin
      if (tx_valid) begin
        tx_ack    = 1'b1;
        state_d   = DATA;
        shift_d   = tx_data;
        last_d    = tx_last;
        bit_cnt_d = 3'd0;
        send      = 1'b1;
        send_val  = tx_data[0];
      end else begin
        tx_err = 1'b1;
        go_eop = 1'b1;
      end
    end

    if (go_eop) begin
      state_d   = EOP_SE0;
      bit_cnt_d = 3'd0;
      dp_d      = 1'b0;
      dm_d      = 1'b0;
    end

    // NRZI: a 0 toggles J<->K, a 1 holds the level and feeds the stuffing run length
    if (send) begin
      ones_d = send_val ? ones_q + 3'd1 : 3'd0;
      if (!send_val) begin
        dp_d = ~dp_q;
        dm_d = ~dm_q;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      timer_q   <= 4'd0;
      bit_cnt_q <= 3'd0;
      ones_q    <= 3'd0;
      shift_q   <= 8'd0;
      last_q    <= 1'b0;
      dp_q      <= 1'b1;
      dm_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same pre-edge values.
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      dp_q      <= dp_d;
      dm_q      <= dm_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder: a bit-period level packet model is expanded to a
// per-cycle expectation and compared against the DUT on every cycle, with randomized stimulus.
module tb_usb_tx_encoder;

  localparam int CPB = 8;
  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ack, tx_busy, tx_done, tx_err, d_plus, d_minus;

  always #5 clk = ~clk;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_last (tx_last),
    .tx_ack  (tx_ack),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx_err  (tx_err),
    .d_plus  (d_plus),
    .d_minus (d_minus)
  );

  typedef struct {
    logic [1:0] line;
    bit         ack;
    bit         err;
    bit         done;
  } period_t;

  typedef struct {
    logic [5:0] outs;   // {d_plus, d_minus, busy, ack, done, err}
    bit         busy;
    bit         cap;
    logic [7:0] data;
    bit         valid;
    bit         last;
  } cyc_t;

  period_t    per_q[$];
  cyc_t       cyc_q[$];
  logic [7:0] pkt[$];
  int         unrun;
  logic [1:0] lvl;
  int         ones;

  int checks   = 0;
  int failures = 0;
  int busy_cnt, done_cnt, err_cnt;
  int ack_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] dut_outs();
    return {d_plus, d_minus, tx_busy, tx_ack, tx_done, tx_err};
  endfunction

  task automatic push_line(input logic [1:0] l);
    period_t p;
    p.line = l;
    p.ack  = 1'b0;
    p.err  = 1'b0;
    p.done = 1'b0;
    per_q.push_back(p);
  endtask

  // One transmitted bit in NRZI, followed by a stuffed 0 after six consecutive ones
  task automatic push_bit(input bit b);
    if (!b) lvl = (lvl == LJ) ? LK : LJ;
    push_line(lvl);
    if (b) begin
      ones++;
      if (ones == 6) begin
        lvl  = (lvl == LJ) ? LK : LJ;
        push_line(lvl);
        ones = 0;
      end
    end else begin
      ones = 0;
    end
  endtask

  task automatic build_model();
    per_q.delete();
    lvl  = LJ;
    ones = 0;
    for (int i = 0; i < 8; i++) push_bit(i == 7);
    for (int b = 0; b < pkt.size(); b++) begin
      if (b == unrun) begin
        per_q[per_q.size()-1].err = 1'b1;
        break;
      end
      per_q[per_q.size()-1].ack = 1'b1;
      for (int i = 0; i < 8; i++) push_bit(pkt[b][i]);
    end
    push_line(LSE0);
    push_line(LSE0);
    push_line(LJ);
    per_q[per_q.size()-1].done = 1'b1;
  endtask

  task automatic build_cycles();
    cyc_t c;
    int   b;
    bit   fin;
    b = 0;
    cyc_q.delete();
    c.outs = {LJ, 4'b0000}; c.busy = 1'b0; c.cap = 1'b0;
    c.data = 8'h00; c.valid = 1'b0; c.last = 1'b0;
    cyc_q.push_back(c);
    foreach (per_q[p]) begin
      for (int t = 0; t < CPB; t++) begin
        fin    = (t == CPB - 1);
        c.outs = {per_q[p].line, 1'b1, per_q[p].ack && fin, per_q[p].done && fin,
                  per_q[p].err && fin};
        c.busy = 1'b1;
        c.cap  = (per_q[p].ack || per_q[p].err) && fin;
        c.valid = 1'b0;
        c.data  = 8'($urandom);
        c.last  = 1'($urandom_range(0, 1));
        if (c.cap && per_q[p].ack) begin
          c.valid = 1'b1;
          c.data  = pkt[b];
          c.last  = (b == pkt.size() - 1);
          b++;
        end
        cyc_q.push_back(c);
      end
    end
    c.outs = {LJ, 4'b0000}; c.busy = 1'b0; c.cap = 1'b0;
    for (int i = 0; i < 3; i++) cyc_q.push_back(c);
  endtask

  // Runs one packet cycle by cycle; abort_at >= 0 pulses reset on that cycle instead of finishing
  task automatic run_packet(input int abort_at);
    build_model();
    build_cycles();
    busy_cnt = 0; done_cnt = 0; err_cnt = 0;
    ack_cyc.delete();
    for (int c = 0; c < cyc_q.size(); c++) begin
      @(posedge clk);
      #1;
      if (c == abort_at) begin
        tx_start = 1'b0;
        n_rst    = 1'b0;
        #1;
        check("outputs during mid-packet reset", 32'(dut_outs()), 32'({LJ, 4'b0000}));
        @(negedge clk);
        check("outputs held in reset", 32'(dut_outs()), 32'({LJ, 4'b0000}));
        n_rst = 1'b1;
        return;
      end
      tx_start = (c == 0) ? 1'b1 : (cyc_q[c].busy && $urandom_range(0, 15) == 0);
      if (cyc_q[c].cap) begin
        tx_data  = cyc_q[c].data;
        tx_valid = cyc_q[c].valid;
        tx_last  = cyc_q[c].last;
      end else begin
        tx_data  = 8'($urandom);
        tx_valid = 1'($urandom_range(0, 1));
        tx_last  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check($sformatf("cycle %0d {dp,dm,busy,ack,done,err}", c), 32'(dut_outs()),
            32'(cyc_q[c].outs));
      if (tx_busy) busy_cnt++;
      if (tx_done) done_cnt++;
      if (tx_err)  err_cnt++;
      if (tx_ack)  ack_cyc.push_back(c);
    end
    tx_start = 1'b0;
  endtask

  logic [1:0] exp_zero [19];

  initial begin
    n_rst    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    #12;
    check("reset outputs", 32'(dut_outs()), 32'({LJ, 4'b0000}));
    @(negedge clk);
    n_rst = 1'b1;

    // Single 0x00 byte: pin the model's line sequence, then run it
    exp_zero = '{LK, LJ, LK, LJ, LK, LJ, LK, LK,
                 LJ, LK, LJ, LK, LJ, LK, LJ, LK,
                 LSE0, LSE0, LJ};
    pkt = '{8'h00};
    unrun = -1;
    build_model();
    check("model 0x00 period count", 32'(per_q.size()), 32'd19);
    for (int i = 0; i < 19 && i < per_q.size(); i++)
      check($sformatf("model 0x00 period %0d line", i), 32'(per_q[i].line), 32'(exp_zero[i]));
    run_packet(-1);
    check("0x00 busy cycles", 32'(busy_cnt), 32'd152);
    check("0x00 ack count", 32'(ack_cyc.size()), 32'd1);
    check("0x00 done count", 32'(done_cnt), 32'd1);

    // Single 0xFF byte: stuff bit after the fifth data bit
    pkt = '{8'hFF};
    build_model();
    check("model 0xFF period count", 32'(per_q.size()), 32'd20);
    check("model 0xFF bit5 line", 32'(per_q[12].line), 32'(LK));
    check("model 0xFF stuff line", 32'(per_q[13].line), 32'(LJ));
    run_packet(-1);
    check("0xFF busy cycles", 32'(busy_cnt), 32'd160);

    // 0x3F then 0x00: second capture delayed one bit period by the stuff bit
    pkt = '{8'h3F, 8'h00};
    run_packet(-1);
    check("0x3F,0x00 ack count", 32'(ack_cyc.size()), 32'd2);
    if (ack_cyc.size() == 2) begin
      check("first ack cycle", 32'(ack_cyc[0]), 32'd64);
      check("second ack cycle", 32'(ack_cyc[1]), 32'd136);
    end

    // Underrun at the first capture
    pkt = '{8'h55};
    unrun = 0;
    run_packet(-1);
    check("underrun busy cycles", 32'(busy_cnt), 32'd88);
    check("underrun ack count", 32'(ack_cyc.size()), 32'd0);
    check("underrun err count", 32'(err_cnt), 32'd1);
    check("underrun done count", 32'(done_cnt), 32'd1);

    // Reset mid-DATA, then a full packet must follow normally
    pkt = '{8'hA5, 8'h5A};
    unrun = -1;
    run_packet(100);
    pkt = '{8'hC3, 8'hFF, 8'h7E};
    run_packet(-1);
    check("post-reset packet done count", 32'(done_cnt), 32'd1);
    check("post-reset packet ack count", 32'(ack_cyc.size()), 32'd3);

    // Randomized packets biased towards long runs of ones
    for (int n = 0; n < 25; n++) begin
      int len;
      len = $urandom_range(1, 4);
      pkt.delete();
      for (int i = 0; i < len; i++)
        pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      unrun = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_packet(-1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
